// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver.
package uart_pkg;

    // Data bits per 8N1 frame.
    localparam int unsigned FrameBits = 8;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Width of a down-counter that must hold values up to max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; empty reads return zero.
module sync_fifo #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthBits = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned Depth = 1 << DepthBits;
    localparam logic [DepthBits:0]   CntOne  = (DepthBits + 1)'(1);
    localparam logic [DepthBits:0]   CntFull = (DepthBits + 1)'(Depth);
    localparam logic [DepthBits-1:0] PtrOne  = DepthBits'(1);

    logic [DepthBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthBits:0]   count_q, count_d;
    logic [Width-1:0]     mem_q [Depth];
    logic [Width-1:0]     mem_d [Depth];
    logic                 do_push, do_pop;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CntFull);
        do_pop  = pop_i && !empty_o;
        // A push into a full FIFO only succeeds when a pop frees a slot this cycle.
        do_push = push_i && (!full_o || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    // Storage and pointer registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with input synchronizer, sticky error flags and a receive FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ            = 20_250_000,
    parameter int unsigned BAUD_RATE           = 9600,
    parameter int unsigned FIFO_DEPTH_BITWIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [FrameBits-1:0] data,
    output logic                 data_valid,
    input  logic                 data_read,
    output logic                 overrun,
    output logic                 framing_error,
    input  logic                 clear_errors
);

    localparam int unsigned BitTime = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HalfBit = BitTime / 2;
    localparam int unsigned CntW    = cnt_width(BitTime);
    localparam int unsigned IdxW    = $clog2(FrameBits);

    localparam logic [CntW-1:0] CntBit  = CntW'(BitTime);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(FrameBits - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [FrameBits-1:0] shift_q, shift_d;
    logic                 stop_wait_q, stop_wait_d;
    logic                 armed_q, armed_d;
    logic [1:0]           settle_q, settle_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;

    logic rx_s;
    logic expire;
    logic push;
    logic frame_err;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    // Two-flop synchronizer for the asynchronous serial line.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        rx_s    = sync2_q;
    end

    // Frame decoder next-state; push and frame_err are single-cycle strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        armed_d     = armed_q;
        push        = 1'b0;
        frame_err   = 1'b0;
        expire      = (cnt_q <= CntOne);
        // Synchronizer holds reset values for two cycles after reset release.
        settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;

        unique case (state_q)
            StIdle: begin
                // A line already low when reset lifts must go high before a start is honoured.
                if (settle_q == 2'd2 && rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    idx_d = '0;
                    if (HalfBit == 0) begin
                        // One-cycle bits: the edge sample itself is the start-bit sample.
                        state_d = StData;
                        cnt_d   = CntBit;
                    end else begin
                        state_d = StStart;
                        cnt_d   = CntHalf;
                    end
                end
            end
            StStart: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_d = StData;
                        cnt_d   = CntBit;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (expire) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = CntBit;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStop: begin
                if (stop_wait_q) begin
                    if (rx_s) begin
                        stop_wait_d = 1'b0;
                        state_d     = StIdle;
                    end
                end else if (expire) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err   = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky error flags; a new event wins over a concurrent clear.
    always_comb begin
        pop       = data_read && data_valid;
        overrun_d = clear_errors ? 1'b0 : overrun_q;
        framing_d = clear_errors ? 1'b0 : framing_q;
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
        if (frame_err) begin
            framing_d = 1'b1;
        end
    end

    // All receiver state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= 2'd0;
            overrun_q   <= 1'b0;
            framing_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            overrun_q   <= overrun_d;
            framing_q   <= framing_d;
        end
    end

    sync_fifo #(
        .Width     (FrameBits),
        .DepthBits (FIFO_DEPTH_BITWIDTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .pop_data_o  (data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign data_valid    = !fifo_empty;
    assign overrun       = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench: one receiver at 10 clocks per bit, one at 1 clock per bit.
module tb_uart_rx_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr;
    logic       rx10, rd10, dv10, ov10, fe10;
    logic       rx1, rd1, dv1, ov1, fe1;
    logic [7:0] data10, data1;

    int checks = 0;
    int errors = 0;

    uart_rx_buffered #(
        .CLK_FREQ            (100),
        .BAUD_RATE           (10),
        .FIFO_DEPTH_BITWIDTH (2)
    ) dut10 (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx10),
        .data          (data10),
        .data_valid    (dv10),
        .data_read     (rd10),
        .overrun       (ov10),
        .framing_error (fe10),
        .clear_errors  (clr)
    );

    uart_rx_buffered #(
        .CLK_FREQ            (10),
        .BAUD_RATE           (10),
        .FIFO_DEPTH_BITWIDTH (2)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx1),
        .data          (data1),
        .data_valid    (dv1),
        .data_read     (rd1),
        .overrun       (ov1),
        .framing_error (fe1),
        .clear_errors  (clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Frame on rx10, 10 cycles per bit; optionally pop on the stop-sample cycle.
    task automatic send10(input logic [7:0] b, input logic stop, input logic pop_at_stop,
                          output logic dv97, output logic dv98);
        logic [9:0] fr;
        fr   = {stop, b, 1'b0};
        dv97 = 1'b0;
        dv98 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 97) dv97 = dv10;
            if (k == 98) dv98 = dv10;
            rx10 = fr[k/10];
            if (pop_at_stop) rd10 = (k == 97);
        end
        @(negedge clk);
        rx10 = 1'b1;
        rd10 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop10();
        @(negedge clk);
        rd10 = 1'b1;
        @(negedge clk);
        rd10 = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        rd1 = 1'b1;
        @(negedge clk);
        rd1 = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic        a, b;
    logic [19:0] stream;
    logic [7:0]  exp_q [4];

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        rx10  = 1'b1;
        rd10  = 1'b0;
        rx1   = 1'b1;
        rd1   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(data10), 32'h0);
        check_eq("rst_valid", 32'(dv10), 32'h0);
        check_eq("rst_overrun", 32'(ov10), 32'h0);
        check_eq("rst_framing", 32'(fe10), 32'h0);
        check_eq("rst_valid_b1", 32'(dv1), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55 at 10 clocks per bit, valid exactly one cycle after the stop sample
        send10(8'h55, 1'b1, 1'b0, a, b);
        check_eq("x55_valid_early", 32'(a), 32'h0);
        check_eq("x55_valid_on_time", 32'(b), 32'h1);
        check_eq("x55_data", 32'(data10), 32'h55);
        check_eq("x55_framing", 32'(fe10), 32'h0);
        check_eq("x55_overrun", 32'(ov10), 32'h0);
        pop10();
        check_eq("x55_pop_valid", 32'(dv10), 32'h0);
        check_eq("x55_pop_data", 32'(data10), 32'h0);

        // 2-cycle glitch is rejected at the start-bit midpoint
        @(negedge clk);
        rx10 = 1'b0;
        repeat (2) @(negedge clk);
        rx10 = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("glitch_valid", 32'(dv10), 32'h0);
        check_eq("glitch_framing", 32'(fe10), 32'h0);
        check_eq("glitch_overrun", 32'(ov10), 32'h0);

        // Bad stop bit, then a good frame
        send10(8'h81, 1'b0, 1'b0, a, b);
        check_eq("ferr_valid", 32'(dv10), 32'h0);
        check_eq("ferr_flag", 32'(fe10), 32'h1);
        send10(8'h7E, 1'b1, 1'b0, a, b);
        check_eq("x7e_data", 32'(data10), 32'h7E);
        check_eq("x7e_valid", 32'(dv10), 32'h1);
        check_eq("ferr_sticky", 32'(fe10), 32'h1);
        pulse_clear();
        check_eq("ferr_cleared", 32'(fe10), 32'h0);
        pop10();
        check_eq("x7e_popped", 32'(dv10), 32'h0);

        // Five bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send10(8'(i), 1'b1, 1'b0, a, b);
        end
        check_eq("ovr_flag", 32'(ov10), 32'h1);
        check_eq("ovr_head", 32'(data10), 32'h01);
        check_eq("ovr_valid", 32'(dv10), 32'h1);
        pulse_clear();
        check_eq("ovr_cleared", 32'(ov10), 32'h0);

        // Full FIFO, pop on the same cycle as the push of 0x99
        send10(8'h99, 1'b1, 1'b1, a, b);
        check_eq("pp_overrun", 32'(ov10), 32'h0);
        exp_q[0] = 8'h02;
        exp_q[1] = 8'h03;
        exp_q[2] = 8'h04;
        exp_q[3] = 8'h99;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pp_drain%0d", i), 32'(data10), 32'(exp_q[i]));
            pop10();
        end
        check_eq("pp_empty_valid", 32'(dv10), 32'h0);
        check_eq("pp_empty_data", 32'(data10), 32'h0);

        // Back-to-back frames at 1 clock per bit
        stream = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rx1 = stream[k];
        end
        @(negedge clk);
        rx1 = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("b1_first", 32'(data1), 32'hA5);
        check_eq("b1_valid", 32'(dv1), 32'h1);
        check_eq("b1_overrun", 32'(ov1), 32'h0);
        check_eq("b1_framing", 32'(fe1), 32'h0);
        pop1();
        check_eq("b1_second", 32'(data1), 32'h3C);
        pop1();
        check_eq("b1_empty_valid", 32'(dv1), 32'h0);
        check_eq("b1_empty_data", 32'(data1), 32'h0);

        // Reset in the middle of a data phase with flags and FIFO populated
        send10(8'h81, 1'b0, 1'b0, a, b);
        send10(8'h11, 1'b1, 1'b0, a, b);
        check_eq("pre_rst_framing", 32'(fe10), 32'h1);
        check_eq("pre_rst_data", 32'(data10), 32'h11);
        @(negedge clk);
        rx10 = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(dv10), 32'h0);
        check_eq("mid_rst_data", 32'(data10), 32'h0);
        check_eq("mid_rst_framing", 32'(fe10), 32'h0);
        check_eq("mid_rst_overrun", 32'(ov10), 32'h0);
        rst_n = 1'b1;
        // Line still low after release: that frame must not be decoded
        repeat (20) @(negedge clk);
        rx10 = 1'b1;
        repeat (120) @(negedge clk);
        check_eq("post_rst_valid", 32'(dv10), 32'h0);
        check_eq("post_rst_framing", 32'(fe10), 32'h0);
        send10(8'h42, 1'b1, 1'b0, a, b);
        check_eq("post_rst_data", 32'(data10), 32'h42);
        check_eq("post_rst_valid2", 32'(dv10), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 20_250_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate; BIT_TIME = CLK_FREQ / BAUD_RATE (integer division), legal range BIT_TIME >= 1.
REQ-003 Parameter FIFO_DEPTH_BITWIDTH, default 2: FIFO holds 2^FIFO_DEPTH_BITWIDTH bytes.
REQ-004 Single clock `clk`; reset `rst_n` is synchronous and active-low.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 rx  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-008 data  output  8  byte at FIFO head; 0 when FIFO empty.
REQ-009 data_valid  output  1  FIFO non-empty.
REQ-010 data_read  input  1  consumer pop strobe; ignored when data_valid is 0.
REQ-011 overrun  output  1  sticky: a received byte was dropped because FIFO was full.
REQ-012 framing_error  output  1  sticky: a stop bit sampled low.
REQ-013 clear_errors  input  1  clears overrun and framing_error.

Function
REQ-014 rx passes a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-015 FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: synchronized rx low -> START, bit counter loaded with BIT_TIME/2 (0 allowed).
REQ-017 START: counter expiry with rx low -> DATA (counter = BIT_TIME, bit index 0); rx high at expiry -> IDLE, no flag (glitch reject).
REQ-018 DATA: at each counter expiry, sample rx into shift register bit [index], reload BIT_TIME; after bit 7 -> STOP.
REQ-019 STOP: at counter expiry, rx high -> push byte, IDLE; rx low -> drop byte, set framing_error, IDLE only after rx returns high.
REQ-020 BIT_TIME == 1: one bit sampled per cycle; no dead cycles between consecutive frames.
REQ-021 Pushed byte visible on data with data_valid high on the cycle after the stop-bit sample.
REQ-022 Pop: data_read && data_valid advances head; next byte (or 0 / data_valid low) visible next cycle.
REQ-023 Push while full and no pop in same cycle: byte dropped, contents unchanged, overrun set.
REQ-024 Push and pop same cycle: both performed, occupancy unchanged, no overrun even when full.
REQ-025 Pointers wrap modulo 2^FIFO_DEPTH_BITWIDTH; count width FIFO_DEPTH_BITWIDTH+1 distinguishes full from empty.
REQ-026 clear_errors concurrent with new error event: set wins.

Reset
REQ-027 rst_n low at a clock edge: FSM -> IDLE, FIFO emptied, data=0, data_valid=0, overrun=0, framing_error=0, synchronizer flops = 1.
REQ-028 Reset mid-frame abandons the partial byte; no push, no flag.
REQ-029 After reset release, a frame whose start edge precedes release is not decoded; next falling edge is.

Structure
REQ-030 Shared package uart_pkg holds the rx FSM state enum and the frame-width constant (8).
REQ-031 Storage implemented in one sub-module sync_fifo (parameterized width/depth, push/pop/full/empty); FSM and synchronizer stay in uart_rx_buffered.

Verification
REQ-032 BIT_TIME=10: send 0x55 -> data=0x55, data_valid=1 one cycle after stop sample, flags 0.
REQ-033 BIT_TIME=1: back-to-back frames 0xA5, 0x3C -> FIFO holds 0xA5 then 0x3C; two pops empty it, data=0.
REQ-034 Depth 4: send 5 bytes 0x01..0x05 without pops -> 0x01..0x04 retained, overrun=1; clear_errors -> overrun=0.
REQ-035 Send 0x81 with stop bit low -> no push, framing_error=1; next valid 0x7E accepted.
REQ-036 FIFO full, pop asserted on same cycle as push of 0x99 -> occupancy stays 4, overrun=0, 0x99 last out.
REQ-037 2-cycle low glitch on rx with BIT_TIME=10 -> no push, no flags; rst_n low mid-DATA -> all outputs reset values.
